// File: rtl/icache_fetch_if.sv
// Bus bundle between the fetch front-end, the icache read port and decode.
// The master modport is the fetch unit; the slave modport is the icache/decode side.
interface icache_fetch_if;
  // icache read port: a request is issued in any cycle with icache_not_enable=0;
  // icache_data carries the addressed halfword in the following cycle.
  logic        icache_not_enable;
  logic [31:0] icache_index;
  logic [15:0] icache_data;

  // Decode handshake: an instruction transfers in a cycle where instr_valid and
  // instr_ready are both 1. While instr_valid=1 and instr_ready=0 the offered
  // instr/instr_addr stay unchanged. instr_valid never depends on instr_ready.
  logic        instr_valid;
  logic [15:0] instr;
  logic [31:0] instr_addr;
  logic        instr_ready;

  // Branch redirect: flushes buffered and in-flight fetches.
  logic        redirect;
  logic [31:0] redirect_addr;

  modport master (
    output icache_not_enable,
    output icache_index,
    input  icache_data,
    output instr_valid,
    output instr,
    output instr_addr,
    input  instr_ready,
    input  redirect,
    input  redirect_addr
  );

  modport slave (
    input  icache_not_enable,
    input  icache_index,
    output icache_data,
    input  instr_valid,
    input  instr,
    input  instr_addr,
    output instr_ready,
    output redirect,
    output redirect_addr
  );
endinterface

// File: rtl/icache_fetch.sv
// Instruction fetch front-end: issues icache reads under a credit limit, buffers
// returned halfwords in a small FIFO and offers them to decode; redirect flushes.
module icache_fetch #(
  parameter logic [30:0] RESET_INDEX = 31'h0,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 not_reset,
  icache_fetch_if.master       bus,
  output logic [1:0]           fetch_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  state_t             cur_state;

  logic [30:0]        fetch_index_q;
  logic               inflight_q;
  logic [30:0]        inflight_idx_q;

  logic [15:0]        data_mem [FIFO_DEPTH];
  logic [30:0]        idx_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic [CNT_W-1:0]   occupancy;
  logic               credit;
  logic               req;
  logic               push;
  logic               pop;
  logic               head_valid;
  logic               unused_addr_bit;

  assign unused_addr_bit = bus.redirect_addr[0];

  // An in-flight read already owns a slot, so it counts against the buffer.
  assign occupancy  = count_q + CNT_W'(inflight_q);
  assign credit     = occupancy < CNT_W'(FIFO_DEPTH);
  assign head_valid = (count_q != '0);

  // State register holds IDLE only until the first clock after reset; after that
  // it records the classification of the previous cycle.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    cur_state = ST_IDLE;
    state_d   = state_q;
    req       = 1'b0;
    if (bus.redirect) begin
      cur_state = ST_FLUSH;
    end else if (state_q == ST_IDLE) begin
      cur_state = ST_IDLE;
    end else if (credit) begin
      cur_state = ST_FETCH;
      req       = 1'b1;
    end else begin
      cur_state = ST_STALL;
    end
    state_d = (cur_state == ST_IDLE) ? ST_FETCH : cur_state;
  end

  assign fetch_state = cur_state;

  // Flush takes priority over both the returning response and a decode pop.
  assign push = inflight_q && !bus.redirect;
  assign pop  = head_valid && bus.instr_ready && !bus.redirect;

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      fetch_index_q  <= RESET_INDEX;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else if (bus.redirect) begin
      fetch_index_q  <= bus.redirect_addr[31:1];
      inflight_q     <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      inflight_q <= req;
      if (req) begin
        fetch_index_q  <= fetch_index_q + 31'd1;
        inflight_idx_q <= fetch_index_q;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Buffer storage carries no reset; the outputs are masked while it is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus.icache_data;
      idx_mem[wr_ptr_q]  <= inflight_idx_q;
    end
  end

  assign bus.icache_not_enable = !req;
  assign bus.icache_index      = {1'b0, fetch_index_q};
  assign bus.instr_valid       = head_valid;
  assign bus.instr             = head_valid ? data_mem[rd_ptr_q] : 16'h0;
  assign bus.instr_addr        = head_valid ? {idx_mem[rd_ptr_q], 1'b0} : 32'h0;

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: two instances (reset index 0 and 7FFF_FFFF)
// each fed by a halfword memory model where mem[i] = i + 0x100.
module tb_icache_fetch;

  logic       clk;
  logic       not_reset;
  logic [1:0] state_a;
  logic [1:0] state_b;
  int         total;
  int         bad;

  icache_fetch_if bus_a ();
  icache_fetch_if bus_b ();

  icache_fetch #(.RESET_INDEX(31'h0), .FIFO_DEPTH(4)) u_dut_a (
    .clk         (clk),
    .not_reset   (not_reset),
    .bus         (bus_a),
    .fetch_state (state_a)
  );

  icache_fetch #(.RESET_INDEX(31'h7FFF_FFFF), .FIFO_DEPTH(4)) u_dut_b (
    .clk         (clk),
    .not_reset   (not_reset),
    .bus         (bus_b),
    .fetch_state (state_b)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [31:0] idx);
    return idx[15:0] + 16'h0100;
  endfunction

  // icache models: data for a request in cycle N is presented in cycle N+1.
  always @(posedge clk) begin
    if (!bus_a.icache_not_enable) bus_a.icache_data <= mem_word(bus_a.icache_index);
    if (!bus_b.icache_not_enable) bus_b.icache_data <= mem_word(bus_b.icache_index);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one tick past release, i.e. in the first cycle that can request.
  task automatic do_reset();
    not_reset = 1'b0;
    tick();
    tick();
    not_reset = 1'b1;
    tick();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad   = 0;
    not_reset = 1'b0;
    bus_a.icache_data   = 16'h0;
    bus_a.instr_ready   = 1'b1;
    bus_a.redirect      = 1'b0;
    bus_a.redirect_addr = 32'h0;
    bus_b.icache_data   = 16'h0;
    bus_b.instr_ready   = 1'b1;
    bus_b.redirect      = 1'b0;
    bus_b.redirect_addr = 32'h0;

    // Reset values while held in reset
    tick();
    tick();
    check("rst_ne",    32'(bus_a.icache_not_enable), 32'h1);
    check("rst_valid", 32'(bus_a.instr_valid), 32'h0);
    check("rst_instr", 32'(bus_a.instr), 32'h0);
    check("rst_addr",  bus_a.instr_addr, 32'h0);
    check("rst_index", bus_a.icache_index, 32'h0);
    check("rst_state", 32'(state_a), 32'h0);
    check("rst_index_b", bus_b.icache_index, 32'h7FFF_FFFF);

    // 1: streaming with ready=1, plus the wrapping instance
    not_reset = 1'b1;
    tick();
    for (int c = 0; c < 8; c++) begin
      check("t1_ne",    32'(bus_a.icache_not_enable), 32'h0);
      check("t1_index", bus_a.icache_index, 32'(c));
      if (c < 2) begin
        check("t1_valid", 32'(bus_a.instr_valid), 32'h0);
      end else begin
        check("t1_valid", 32'(bus_a.instr_valid), 32'h1);
        check("t1_instr", 32'(bus_a.instr), 32'h100 + 32'(c - 2));
        check("t1_addr",  bus_a.instr_addr, 32'(2 * (c - 2)));
      end
      if (c == 0) check("t6_index0", bus_b.icache_index, 32'h7FFF_FFFF);
      if (c == 1) check("t6_index1", bus_b.icache_index, 32'h0);
      if (c == 2) begin
        check("t6_addr0",  bus_b.instr_addr, 32'hFFFF_FFFE);
        check("t6_instr0", 32'(bus_b.instr), 32'h00FF);
      end
      if (c == 3) begin
        check("t6_addr1",  bus_b.instr_addr, 32'h0);
        check("t6_instr1", 32'(bus_b.instr), 32'h0100);
      end
      tick();
    end

    // 2: ready=0 fills the buffer, then drains with no gap
    bus_a.instr_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      check("t2_ne",    32'(bus_a.icache_not_enable), 32'h0);
      check("t2_index", bus_a.icache_index, 32'(c));
      tick();
    end
    check("t2_stall_ne",    32'(bus_a.icache_not_enable), 32'h1);
    check("t2_stall_index", bus_a.icache_index, 32'h4);
    check("t2_stall_state", 32'(state_a), 32'h2);
    check("t2_head",        32'(bus_a.instr), 32'h100);
    tick();
    check("t2_full_ne", 32'(bus_a.icache_not_enable), 32'h1);
    tick();
    check("t2_full_ne2", 32'(bus_a.icache_not_enable), 32'h1);
    bus_a.instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("t2_valid", 32'(bus_a.instr_valid), 32'h1);
      check("t2_instr", 32'(bus_a.instr), 32'h100 + 32'(k));
      check("t2_addr",  bus_a.instr_addr, 32'(2 * k));
      if (k == 1) begin
        check("t2_resume_ne",    32'(bus_a.icache_not_enable), 32'h0);
        check("t2_resume_index", bus_a.icache_index, 32'h4);
      end
      tick();
    end

    // 3: redirect with two buffered entries and one in flight
    bus_a.instr_ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    bus_a.redirect      = 1'b1;
    bus_a.redirect_addr = 32'h20;
    bus_a.instr_ready   = 1'b1;
    #1;
    check("t3_r_ne",    32'(bus_a.icache_not_enable), 32'h1);
    check("t3_r_state", 32'(state_a), 32'h3);
    tick();
    bus_a.redirect    = 1'b0;
    bus_a.instr_ready = 1'b0;
    #1;
    check("t3_r1_valid", 32'(bus_a.instr_valid), 32'h0);
    check("t3_r1_ne",    32'(bus_a.icache_not_enable), 32'h0);
    check("t3_r1_index", bus_a.icache_index, 32'h10);
    tick();
    check("t3_r2_index", bus_a.icache_index, 32'h11);
    check("t3_r2_valid", 32'(bus_a.instr_valid), 32'h0);
    tick();
    check("t3_r3_valid", 32'(bus_a.instr_valid), 32'h1);
    check("t3_r3_instr", 32'(bus_a.instr), 32'h110);
    check("t3_r3_addr",  bus_a.instr_addr, 32'h20);
    tick();
    check("t3_hold_instr", 32'(bus_a.instr), 32'h110);
    check("t3_hold_addr",  bus_a.instr_addr, 32'h20);
    bus_a.instr_ready = 1'b1;
    tick();
    check("t3_next_instr", 32'(bus_a.instr), 32'h111);
    check("t3_next_addr",  bus_a.instr_addr, 32'h22);

    // 4: odd redirect address held for three cycles
    do_reset();
    check("t4_c0_index", bus_a.icache_index, 32'h0);
    tick();
    bus_a.redirect      = 1'b1;
    bus_a.redirect_addr = 32'h21;
    #1;
    check("t4_h0_ne", 32'(bus_a.icache_not_enable), 32'h1);
    tick();
    check("t4_h1_ne",    32'(bus_a.icache_not_enable), 32'h1);
    check("t4_h1_index", bus_a.icache_index, 32'h10);
    check("t4_h1_valid", 32'(bus_a.instr_valid), 32'h0);
    tick();
    check("t4_h2_ne", 32'(bus_a.icache_not_enable), 32'h1);
    tick();
    bus_a.redirect = 1'b0;
    #1;
    check("t4_go_ne",    32'(bus_a.icache_not_enable), 32'h0);
    check("t4_go_index", bus_a.icache_index, 32'h10);
    tick();
    check("t4_go1_index", bus_a.icache_index, 32'h11);
    tick();
    check("t4_instr0", 32'(bus_a.instr), 32'h110);
    check("t4_addr0",  bus_a.instr_addr, 32'h20);
    tick();
    check("t4_instr1", 32'(bus_a.instr), 32'h111);
    check("t4_addr1",  bus_a.instr_addr, 32'h22);

    // 5: asynchronous reset mid-cycle while streaming
    tick();
    #2;
    not_reset = 1'b0;
    #1;
    check("t5_ne",    32'(bus_a.icache_not_enable), 32'h1);
    check("t5_valid", 32'(bus_a.instr_valid), 32'h0);
    check("t5_instr", 32'(bus_a.instr), 32'h0);
    check("t5_addr",  bus_a.instr_addr, 32'h0);
    check("t5_index", bus_a.icache_index, 32'h0);
    check("t5_index_b", bus_b.icache_index, 32'h7FFF_FFFF);
    tick();
    not_reset = 1'b1;
    tick();
    check("t5_restart_index", bus_a.icache_index, 32'h0);
    check("t5_restart_ne",    32'(bus_a.icache_not_enable), 32'h0);
    tick();
    tick();
    check("t5_restart_instr", 32'(bus_a.instr), 32'h100);
    check("t5_restart_addr",  bus_a.instr_addr, 32'h0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
